regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: A (ALU result) and B (memory load data).
- Valid/ready handshake per requester; round-robin arbitration; one registered output stage driving the register file.
- Writes to the zero register (X31) are accepted and discarded; a stall counter supports performance debug.
- Sits between the execute/memory stages and the register file in the LEGv8 datapath.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 42 ++++
 rtl/regfile_wr_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DATA_W / ADDR_W / ZERO_REG / CNT_W : default widths and the discarded register index
//   wr_req_t                           : one writeback request (destination + data)
//   req_id_e                           : requester identity, used for the last-grant record
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned CNT_W    = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request vector, bit 0 = requester A, bit 1 = requester B
//   advance    : a transfer happened this cycle; record the current grant
//   gnt[1:0]   : one-hot grant, all zero while reset is asserted
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  import regfile_pkg::*;

  req_id_e last_grant;
  req_id_e last_grant_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      // B as the last winner means A takes the first tie.
      last_grant <= REQ_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    gnt             = 2'b00;
    last_grant_next = last_grant;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
    if (advance) begin
      last_grant_next = gnt[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port (we3/wa3/wd3) between the ALU (A) and
// load (B) writeback requesters.
//   a_valid/a_addr/a_data/a_ready : requester A handshake
//   b_valid/b_addr/b_data/b_ready : requester B handshake
//   we3/wa3/wd3                   : registered register-file write port
//   pending                       : one-hot of the register written this cycle
//   stall_cnt                     : saturating count of cycles a valid requester was refused
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG,
  parameter int unsigned CNT_W    = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       pending,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  logic              keep;
  logic              stall;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign req = {b_valid, a_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign xfer     = |(req & gnt);
  assign sel_addr = gnt[1] ? b_addr : a_addr;
  assign sel_data = gnt[1] ? b_data : a_data;

  // Zero-register writes complete the handshake but never reach the port.
  assign keep  = xfer && (sel_addr != ADDR_W'(ZERO_REG));
  assign stall = (a_valid && !a_ready) || (b_valid && !b_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= keep;
      if (keep) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end

  always_comb begin
    pending = '0;
    if (we3) begin
      pending = 32'd1 << wa3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [31:0] pending;
  logic [15:0] stall_cnt;

  logic        sat_a_ready, sat_b_ready, sat_we3;
  logic [4:0]  sat_wa3;
  logic [63:0] sat_wd3;
  logic [31:0] sat_pending;
  logic [2:0]  sat_stall;

  logic [63:0] rf [32];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter u_dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .pending   (pending),
    .stall_cnt (stall_cnt)
  );

  // Narrow counter instance with both requesters always valid: one stall per cycle.
  regfile_wr_arbiter #(.CNT_W(3)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (1'b1),
    .a_addr    (5'd1),
    .a_data    (64'd1),
    .a_ready   (sat_a_ready),
    .b_valid   (1'b1),
    .b_addr    (5'd2),
    .b_data    (64'd2),
    .b_ready   (sat_b_ready),
    .we3       (sat_we3),
    .wa3       (sat_wa3),
    .wd3       (sat_wd3),
    .pending   (sat_pending),
    .stall_cnt (sat_stall)
  );

  // Register file as seen by the write port.
  always @(posedge clk) begin
    if (we3) rf[wa3] <= wd3;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b1; a_addr = 5'd0; a_data = '0;
    b_valid = 1'b1; b_addr = 5'd0; b_data = '0;

    // Readies held low during reset, reset values
    #1;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    tick();
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_pending", pending, 0);
    check("rst_stall", stall_cnt, 0);
    do_reset();

    // Single A write to X5
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEAD;
    #1;
    check("t1_a_ready", a_ready, 1);
    check("t1_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check("t1_we3", we3, 1);
    check("t1_wa3", wa3, 5);
    check("t1_wd3", wd3, 64'hDEAD);
    check("t1_pending", pending, 32'h20);
    tick();
    check("t1_idle_we3", we3, 0);
    check("t1_idle_pending", pending, 0);
    check("t1_hold_wa3", wa3, 5);
    check("t1_hold_wd3", wd3, 64'hDEAD);
    check("t1_stall", stall_cnt, 0);

    // Tie after reset: A first, then B
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'd10;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'd20;
    #1;
    check("t2_a_first", a_ready, 1);
    check("t2_b_wait", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check("t2_wa3_a", wa3, 1);
    check("t2_wd3_a", wd3, 10);
    #1;
    check("t2_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("t2_wa3_b", wa3, 2);
    check("t2_wd3_b", wd3, 20);
    check("t2_pending_b", pending, 32'h4);
    check("t2_stall", stall_cnt, 1);

    // Continuous contention: strict alternation
    do_reset();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 64'd100;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 64'd200;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t3_a_ready", a_ready, ((i % 2) == 0));
      check("t3_b_ready", b_ready, ((i % 2) == 1));
      tick();
      if ((i % 2) == 0) begin
        check("t3_wa3_a", wa3, a_addr);
        check("t3_wd3_a", wd3, a_data);
        a_addr = a_addr + 5'd1;
        a_data = a_data + 64'd1;
      end else begin
        check("t3_wa3_b", wa3, b_addr);
        check("t3_wd3_b", wd3, b_data);
        b_addr = b_addr + 5'd1;
        b_data = b_data + 64'd1;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("t3_stall", stall_cnt, 6);

    // Zero-register write from B is swallowed, but B still owns last grant
    do_reset();
    b_valid = 1'b1; b_addr = 5'd31; b_data = 64'h1;
    #1;
    check("t4_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("t4_we3", we3, 0);
    check("t4_pending", pending, 0);
    check("t4_wa3", wa3, 0);
    check("t4_wd3", wd3, 0);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'd33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 64'd44;
    #1;
    check("t4_tie_a", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("t4_wa3_a", wa3, 3);
    tick();
    b_valid = 1'b0;
    check("t4_wa3_b", wa3, 4);
    check("t4_wd3_b", wd3, 44);

    // Same destination X7, last grant A: B then A, A's data survives
    do_reset();
    a_valid = 1'b1; a_addr = 5'd8; a_data = 64'd8;
    tick();
    a_addr = 5'd7; a_data = 64'hAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hBB;
    #1;
    check("t5_b_first", b_ready, 1);
    check("t5_a_wait", a_ready, 0);
    tick();
    b_valid = 1'b0;
    check("t5_wd3_b", wd3, 64'hBB);
    tick();
    a_valid = 1'b0;
    check("t5_wd3_a", wd3, 64'hAA);
    tick();
    check("t5_rf_x7", rf[7], 64'hAA);

    // Reset lands on an in-flight write
    do_reset();
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'd99;
    tick();
    a_valid = 1'b0;
    reset   = 1'b1;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 64'd12;
    check("t6_inflight_we3", we3, 1);
    tick();
    check("t6_cancel_we3", we3, 0);
    check("t6_cancel_pending", pending, 0);
    check("t6_stall_clr", stall_cnt, 0);
    reset   = 1'b0;
    a_valid = 1'b1; a_addr = 5'd11; a_data = 64'd11;
    #1;
    check("t6_tie_a", a_ready, 1);
    check("t6_tie_b", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check("t6_wa3_a", wa3, 11);
    tick();
    b_valid = 1'b0;
    check("t6_wa3_b", wa3, 12);

    // Stall counter saturation on the 3-bit instance
    do_reset();
    repeat (4) tick();
    check("sat_count4", sat_stall, 4);
    repeat (3) tick();
    check("sat_count7", sat_stall, 7);
    tick();
    check("sat_hold", sat_stall, 7);
    repeat (3) tick();
    check("sat_hold_more", sat_stall, 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
